// File: rtl/csa_accum.sv
// Carry-save accumulator: reduces NUM_OPS operands per beat plus the stored sum/carry pair
// through a 3:2 compressor tree, then resolves the total with one carry-propagate add on flush.
module csa_accum #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned NUM_OPS   = 4,
    parameter int unsigned ACC_WIDTH = 12,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_OPS*WIDTH-1:0]   in_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_WIDTH-1:0]       out_sum,
    output logic [CNT_WIDTH-1:0]       out_cnt
);

    typedef enum logic [1:0] {StAcc, StResolve, StOut} state_e;

    localparam int unsigned NumVec  = NUM_OPS + 2;
    // Each 3:2 stage retires three slots and appends two, so the tree needs 3*NumVec-4 slots.
    localparam int unsigned NumSlot = 3 * NumVec - 4;

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] s_q, s_d, c_q, c_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;

    logic [ACC_WIDTH-1:0] base_s, base_c;
    logic [CNT_WIDTH-1:0] base_cnt;
    logic [ACC_WIDTH-1:0] vec [NumSlot];
    logic [ACC_WIDTH-1:0] tree_s, tree_c;

    // clr takes effect before any beat arriving in the same cycle.
    assign base_s   = clr ? '0 : s_q;
    assign base_c   = clr ? '0 : c_q;
    assign base_cnt = clr ? '0 : cnt_q;

    always_comb begin
        for (int i = 0; i < int'(NumSlot); i++) begin
            vec[i] = '0;
        end
        for (int i = 0; i < int'(NUM_OPS); i++) begin
            vec[i] = ACC_WIDTH'(in_data[i*WIDTH +: WIDTH]);
        end
        vec[NUM_OPS]     = base_s;
        vec[NUM_OPS + 1] = base_c;
        for (int k = 0; k < int'(NumVec) - 2; k++) begin
            vec[int'(NumVec) + 2*k]     = vec[3*k] ^ vec[3*k+1] ^ vec[3*k+2];
            vec[int'(NumVec) + 2*k + 1] = ((vec[3*k] & vec[3*k+1]) |
                                           (vec[3*k] & vec[3*k+2]) |
                                           (vec[3*k+1] & vec[3*k+2])) << 1;
        end
        tree_s = vec[NumSlot-2];
        tree_c = vec[NumSlot-1];
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        out_sum_d = out_sum_q;
        out_cnt_d = out_cnt_q;
        unique case (state_q)
            StAcc: begin
                s_d   = base_s;
                c_d   = base_c;
                cnt_d = base_cnt;
                if (in_valid) begin
                    s_d   = tree_s;
                    c_d   = tree_c;
                    cnt_d = (&base_cnt) ? base_cnt : base_cnt + CNT_WIDTH'(1);
                end
                if (flush) begin
                    state_d = StResolve;
                end
            end
            StResolve: begin
                out_sum_d = s_q + c_q;
                out_cnt_d = cnt_q;
                s_d       = '0;
                c_d       = '0;
                cnt_d     = '0;
                state_d   = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StAcc;
            s_q       <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            out_sum_q <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            out_sum_q <= out_sum_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign in_ready  = (state_q == StAcc);
    assign out_valid = (state_q == StOut);
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_csa_accum.sv
// Directed bench for csa_accum with an integer-arithmetic reference model checked every cycle.
module tb_csa_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [11:0] out_sum;
    logic [7:0]  out_cnt;

    int vectors = 0;
    int errors  = 0;

    csa_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ops_sum(input logic [15:0] d);
        return int'(d[3:0]) + int'(d[7:4]) + int'(d[11:8]) + int'(d[15:12]);
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Model: 0 = accepting, 1 = resolving, 2 = result held.
    int m_phase, m_sum, m_cnt, m_osum, m_ocnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_sum   <= 0;
            m_cnt   <= 0;
            m_osum  <= 0;
            m_ocnt  <= 0;
        end else if (m_phase == 0) begin
            m_sum <= ((clr ? 0 : m_sum) + (in_valid ? ops_sum(in_data) : 0)) % 4096;
            m_cnt <= in_valid ? sat_inc(clr ? 0 : m_cnt) : (clr ? 0 : m_cnt);
            if (flush) m_phase <= 1;
        end else if (m_phase == 1) begin
            m_osum  <= m_sum;
            m_ocnt  <= m_cnt;
            m_sum   <= 0;
            m_cnt   <= 0;
            m_phase <= 2;
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        check("model in_ready", int'(in_ready), int'(m_phase == 0));
        check("model out_valid", int'(out_valid), int'(m_phase == 2));
        check("model out_sum", int'(out_sum), m_osum);
        check("model out_cnt", int'(out_cnt), m_ocnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int es, input int ec);
        int n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, " valid"}, int'(out_valid), 1);
        check({tag, " sum"}, int'(out_sum), es);
        check({tag, " cnt"}, int'(out_cnt), ec);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " back to acc"}, int'(in_ready), 1);
    endtask

    initial begin
        #1;
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_sum", int'(out_sum), 0);
        check("reset out_cnt", int'(out_cnt), 0);
        step();
        step();
        rst_n = 1'b1;
        check("post-reset in_ready", int'(in_ready), 1);

        // Mid-cycle reset discards an accumulated beat.
        in_valid = 1'b1; in_data = 16'h1111;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async reset in_ready", int'(in_ready), 1);
        check("async reset out_valid", int'(out_valid), 0);
        step();
        rst_n = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        expect_out("empty after reset", 0, 0);

        // Single beat, flush next cycle; one RESOLVE cycle before valid.
        in_valid = 1'b1; in_data = 16'h1111;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("single resolve valid", int'(out_valid), 0);
        check("single resolve ready", int'(in_ready), 0);
        step();
        check("single latency valid", int'(out_valid), 1);
        expect_out("single", 4, 1);

        // Three back-to-back beats with flush on the third.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'hFFFF;
        step();
        step();
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("stream resolve ready", int'(in_ready), 0);
        step();
        check("stream out ready", int'(in_ready), 0);
        check("stream sum", int'(out_sum), 180);
        check("stream cnt", int'(out_cnt), 3);
        step();
        check("stream reopen", int'(in_ready), 1);
        out_ready = 1'b0;

        // Wrap-around modulo 4096.
        in_valid = 1'b1; in_data = 16'hFFFF;
        repeat (69) step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        expect_out("wrap", 44, 69);

        // Backpressure: result holds and nothing is accepted.
        in_valid = 1'b1; in_data = 16'h4321;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'hFFFF; flush = i[0];
            step();
            check("bp valid", int'(out_valid), 1);
            check("bp sum", int'(out_sum), 10);
            check("bp cnt", int'(out_cnt), 1);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp release", int'(in_ready), 1);
        in_valid = 1'b1; in_data = 16'h2222; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        expect_out("after bp", 8, 1);

        // clr priority.
        in_valid = 1'b1; in_data = 16'h3333;
        step();
        step();
        clr = 1'b1; in_data = 16'h1032;
        step();
        clr = 1'b0; in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        expect_out("clr with beat", 6, 1);
        in_valid = 1'b1; in_data = 16'h5555;
        step();
        in_valid = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        expect_out("clr alone", 0, 0);
        in_valid = 1'b1; in_data = 16'h1111;
        step();
        clr = 1'b1; flush = 1'b1; in_data = 16'h2222;
        step();
        clr = 1'b0; flush = 1'b0; in_valid = 1'b0;
        expect_out("clr flush beat", 8, 1);

        // Beat counter saturation.
        in_valid = 1'b1; in_data = 16'h0001;
        repeat (300) step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        expect_out("saturate", 300, 255);

        // Reset while holding a result.
        in_valid = 1'b1; in_data = 16'h1111;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("pre-reset valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset in out valid", int'(out_valid), 0);
        check("reset in out sum", int'(out_sum), 0);
        step();
        rst_n = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        expect_out("after out reset", 0, 0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
